// File: rtl/teclado_ps2.sv
`default_nettype none
// ============================================================================
// Module   : teclado_ps2
// Purpose  : PS/2 keyboard receiver. Deserialises 11-bit device-to-host
//            frames into a scancode FIFO and exposes a 32-bit status/data
//            word on the keyboard slot of the processor read mux. Stores to
//            the slot pop the FIFO (bit 0) and clear error flags (bit 1).
// Revision : 1.0 - initial release
// ============================================================================
module teclado_ps2 #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        sel,
    input  logic        memWr,
    input  logic [31:0] datoIn,
    output logic [31:0] datoOut,
    output logic        hayTecla
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYC - 1);
    localparam logic [c_CW-1:0] c_FULL    = c_CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        c_IDLE   = 2'd0,
        c_DATA   = 2'd1,
        c_PARITY = 2'd2,
        c_STOP   = 2'd3
    } state_t;

    // Synchronisers and edge detection
    logic            r_clk_s1, r_clk_s2, r_clk_prev;
    logic            r_dat_s1, r_dat_s2;
    logic            w_fall;
    logic            w_bit;

    // Receiver
    state_t          r_state, w_state_nxt;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [c_TW-1:0] r_to;
    logic            w_timeout;
    logic            w_push_req;
    logic            w_ferr_set;

    // FIFO and flags
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_ovf, r_ferr;
    logic            w_empty, w_full;
    logic            w_cmd, w_pop, w_clr, w_push, w_ovf_set;
    logic [7:0]      w_head;
    logic            w_unused;

    // Only the two low command bits carry meaning
    assign w_unused = &{1'b0, datoIn[31:2]};

    // Two-stage synchronisers on both pins plus the previous-clock register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;
    assign w_bit  = r_dat_s2;

    // Receiver state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; frame verdict is produced on the stop-bit edge
    always_comb begin
        w_state_nxt = r_state;
        w_push_req  = 1'b0;
        w_ferr_set  = 1'b0;
        w_timeout   = (r_state != c_IDLE) && !w_fall && (r_to == c_TO_LAST);
        if (w_fall) begin
            case (r_state)
                c_IDLE:   if (!w_bit) w_state_nxt = c_DATA;
                c_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = c_PARITY;
                c_PARITY: w_state_nxt = c_STOP;
                c_STOP: begin
                    w_state_nxt = c_IDLE;
                    if (w_bit && ((^r_shift) ^ r_par)) begin
                        w_push_req = 1'b1;
                    end else begin
                        w_ferr_set = 1'b1;
                    end
                end
                default:  w_state_nxt = c_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = c_IDLE;
        end
    end

    // Bit counter, shift register, parity bit and inactivity counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_par    <= 1'b0;
            r_to     <= '0;
        end else begin
            if (w_fall || w_timeout || (r_state == c_IDLE)) begin
                r_to <= '0;
            end else begin
                r_to <= r_to + c_TW'(1);
            end
            if (w_fall) begin
                case (r_state)
                    c_IDLE: r_bitcnt <= 3'd0;
                    c_DATA: begin
                        r_shift  <= {w_bit, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    c_PARITY: r_par <= w_bit;
                    default:  ;
                endcase
            end
        end
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_cmd     = sel & memWr;
    assign w_pop     = w_cmd & datoIn[0] & ~w_empty;
    assign w_clr     = w_cmd & datoIn[1];
    // A pop on the same edge frees the slot a full FIFO would otherwise lack
    assign w_push    = w_push_req & (~w_full | w_pop);
    assign w_ovf_set = w_push_req & w_full & ~w_pop;

    // FIFO storage; contents are only observed when the count says valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: ;
            endcase
        end
    end

    // Sticky error flags; a set on the clearing edge takes priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_clr) begin
                r_ovf  <= 1'b0;
                r_ferr <= 1'b0;
            end
            if (w_ovf_set)  r_ovf  <= 1'b1;
            if (w_ferr_set) r_ferr <= 1'b1;
        end
    end

    // Status/data word assembled from registered state only
    always_comb begin
        w_head   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
        datoOut  = {21'b0, r_ferr, r_ovf, ~w_empty, w_head};
        hayTecla = ~w_empty;
    end

endmodule
`default_nettype wire

// File: tb/tb_teclado_ps2.sv
`default_nettype none
// ============================================================================
// Module   : tb_teclado_ps2
// Purpose  : Self-checking bench for teclado_ps2. A queue-based model of the
//            scancode FIFO and flags is compared against the DUT every cycle;
//            literal expectations pin the model at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_teclado_ps2;

    localparam int DEPTH = 4;
    localparam int TO    = 5000;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic        sel      = 1'b0;
    logic        memWr    = 1'b0;
    logic [31:0] datoIn   = 32'h0;
    logic [31:0] datoOut;
    logic        hayTecla;

    teclado_ps2 #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .sel      (sel),
        .memWr    (memWr),
        .datoIn   (datoIn),
        .datoOut  (datoOut),
        .hayTecla (hayTecla)
    );

    always #5 clk = ~clk;

    // Model state
    logic [7:0]  q[$];
    bit          m_ovf  = 1'b0;
    bit          m_ferr = 1'b0;
    bit          chk_en = 1'b0;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          n_prints = 0;
    int          lit_req  = 0;
    int          lit_done = 0;
    logic [31:0] lit_exp  = 32'h0;
    string       lit_name = "";

    function automatic logic [31:0] model_word();
        logic ne;
        ne = (q.size() != 0);
        return {21'b0, m_ferr, m_ovf, ne, (ne ? q[0] : 8'h00)};
    endfunction

    function automatic void model_cmd(input logic [31:0] v);
        if (v[0] && q.size() > 0) void'(q.pop_front());
        if (v[1]) begin
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end
    endfunction

    function automatic void model_frame(input logic [7:0] d, input bit good);
        if (good) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovf = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endfunction

    // Single compare process: model every cycle, plus pending literal checks
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (datoOut !== model_word()) begin
                n_errs++;
                if (n_prints < 40) begin
                    n_prints++;
                    $display("FAIL datoOut t=%0t actual=%h required=%h", $time, datoOut, model_word());
                end
            end
            n_checks++;
            if (hayTecla !== (q.size() != 0)) begin
                n_errs++;
                if (n_prints < 40) begin
                    n_prints++;
                    $display("FAIL hayTecla t=%0t actual=%b required=%b", $time, hayTecla, (q.size() != 0));
                end
            end
        end
        if (lit_req != lit_done) begin
            lit_done = lit_req;
            n_checks++;
            if (datoOut !== lit_exp) begin
                n_errs++;
                $display("FAIL %s actual=%h required=%h", lit_name, datoOut, lit_exp);
            end
            n_checks++;
            if (model_word() !== lit_exp) begin
                n_errs++;
                $display("FAIL %s(model) actual=%h required=%h", lit_name, model_word(), lit_exp);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] e);
        @(negedge clk); #1;
        lit_name = nm;
        lit_exp  = e;
        lit_req++;
        @(negedge clk); #1;
    endtask

    task automatic store(input logic [31:0] v);
        @(negedge clk); #1;
        sel = 1'b1; memWr = 1'b1; datoIn = v;
        model_cmd(v);
        @(posedge clk); #1;
        sel = 1'b0; memWr = 1'b0; datoIn = 32'h0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk); #1;
        ps2_data = b;
        repeat (10) @(negedge clk);
        #1 ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    // Full frame; cmd (if non-zero) is stored on the edge that sees the stop bit
    task automatic send_frame(input logic [7:0] d, input logic flip_par,
                              input logic stop, input logic [31:0] cmd);
        logic p;
        p = (~^d) ^ flip_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        @(negedge clk); #1;
        ps2_data = stop;
        repeat (10) @(negedge clk);
        #1 ps2_clk = 1'b0;
        // Fall is seen two syncs later; the frame lands on the third edge
        @(negedge clk);
        @(negedge clk); #1;
        if (cmd != 32'h0) begin
            sel = 1'b1; memWr = 1'b1; datoIn = cmd;
            model_cmd(cmd);
        end
        model_frame(d, (stop == 1'b1) && (((^d) ^ p) == 1'b1));
        @(posedge clk); #1;
        sel = 1'b0; memWr = 1'b0; datoIn = 32'h0;
        repeat (18) @(negedge clk);
        #1 ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] d, input int n);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(d[i]);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        #1 rst_n = 1'b1;
        lit("reset", 32'h0);

        // Single good frame, read without side effect, then pop
        send_frame(8'h1C, 1'b0, 1'b1, 32'h0);
        lit("frame_1C", 32'h0000011C);
        @(negedge clk); #1;
        sel = 1'b1; memWr = 1'b0; datoIn = 32'h3;
        repeat (3) @(negedge clk);
        #1 sel = 1'b0; datoIn = 32'h0;
        lit("read_no_side_effect", 32'h0000011C);
        store(32'h1);
        lit("pop_to_empty", 32'h0);

        // Parity error, then clear
        send_frame(8'h1C, 1'b1, 1'b1, 32'h0);
        lit("parity_err", 32'h00000400);
        store(32'h2);
        lit("clear_ferr", 32'h0);

        // Overflow with depth 4
        send_frame(8'h1C, 1'b0, 1'b1, 32'h0);
        send_frame(8'h1D, 1'b0, 1'b1, 32'h0);
        send_frame(8'h1B, 1'b0, 1'b1, 32'h0);
        send_frame(8'h23, 1'b0, 1'b1, 32'h0);
        send_frame(8'h2B, 1'b0, 1'b1, 32'h0);
        lit("overflow", 32'h0000031C);
        store(32'h1);
        lit("pop1", 32'h0000031D);
        store(32'h1);
        lit("pop2", 32'h0000031B);
        store(32'h1);
        lit("pop3", 32'h00000323);
        store(32'h1);
        lit("pop4_empty", 32'h00000200);
        store(32'h1);
        lit("pop_empty_ignored", 32'h00000200);
        store(32'h2);
        lit("clear_ovf", 32'h0);

        // Partial frame abandoned by timeout
        send_partial(8'h55, 4);
        repeat (TO + 10) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b1, 32'h0);
        lit("after_timeout", 32'h00000129);
        store(32'h1);

        // Stop bit 0, then stop-bit error coincident with a clear
        send_frame(8'h1C, 1'b0, 1'b0, 32'h0);
        lit("stop_err", 32'h00000400);
        store(32'h2);
        send_frame(8'h1C, 1'b0, 1'b0, 32'h2);
        lit("set_beats_clear", 32'h00000400);
        store(32'h2);
        lit("clear_again", 32'h0);

        // Push and pop on the same edge: full FIFO, then empty FIFO
        send_frame(8'h1C, 1'b0, 1'b1, 32'h0);
        send_frame(8'h1D, 1'b0, 1'b1, 32'h0);
        send_frame(8'h1B, 1'b0, 1'b1, 32'h0);
        send_frame(8'h23, 1'b0, 1'b1, 32'h0);
        lit("full", 32'h0000011C);
        send_frame(8'h2B, 1'b0, 1'b1, 32'h1);
        lit("full_push_pop", 32'h0000011D);
        repeat (4) store(32'h1);
        lit("drained", 32'h0);
        send_frame(8'h29, 1'b0, 1'b1, 32'h1);
        lit("empty_push_pop", 32'h00000129);
        store(32'h1);

        // Reset in the middle of a frame
        send_partial(8'h5A, 5);
        do_reset();
        lit("mid_reset", 32'h0);
        send_frame(8'h1C, 1'b0, 1'b1, 32'h0);
        lit("after_mid_reset", 32'h0000011C);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
